ieee754_divider: RTL and testbench

- Sequential single-precision IEEE-754 divider: quotient_o = a_i / b_i.
- Uses the same start/done handshake and status-flag style as the team's FP32 multiplier, so both can share a datapath sequencer.
- Mantissa quotient comes from a radix-2 restoring divider, one quotient bit per cycle.
- Denormal inputs are flushed to zero. Rounding is truncation (round toward zero).

---
 rtl/ieee754_divider.sv | 141 ++++++++++++++
 tb/tb_ieee754_divider.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee754_divider.sv
// rtl/ieee754_divider.sv - sequential FP32 divider, radix-2 restoring mantissa divide, truncating.
// Denormals flush to zero; start/done handshake with registered result and status flags.
module ieee754_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic        nan_o,
  output logic        infinite_o,
  output logic        div_by_zero_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORMALIZE, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] a_r, b_r;
  logic [25:0] rem;
  logic [24:0] q;
  logic [4:0]  cnt;

  logic [31:0] res_n;
  logic [4:0]  flg_n;
  logic        load_res;

  logic        sign;
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [25:0] d_ext, rem_sub;
  logic [9:0]  e_n;

  assign sign    = a_r[31] ^ b_r[31];
  assign ea      = a_r[30:23];
  assign eb      = b_r[30:23];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
  assign d_ext   = {2'b00, 1'b1, b_r[22:0]};
  assign rem_sub = rem - d_ext;
  // 10-bit two's-complement exponent; the bias depends on whether the quotient carried an integer bit
  assign e_n     = {2'b00, ea} - {2'b00, eb} + (q[24] ? 10'd127 : 10'd126);

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_comb begin
    state_n  = state;
    res_n    = 32'd0;
    flg_n    = 5'd0;
    load_res = 1'b0;
    case (state)
      IDLE: if (start_i) state_n = UNPACK;
      UNPACK: begin
        state_n  = DONE;
        load_res = 1'b1;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
          res_n = 32'h7FC00000;
          flg_n = 5'b10000;
        end else if (a_inf) begin
          res_n = {sign, 8'hFF, 23'd0};
          flg_n = 5'b01000;
        end else if (b_zero) begin
          res_n = {sign, 8'hFF, 23'd0};
          flg_n = 5'b01100;
        end else if (a_zero || b_inf) begin
          res_n = {sign, 31'd0};
        end else begin
          state_n  = DIVIDE;
          load_res = 1'b0;
        end
      end
      DIVIDE: if (cnt == 5'd24) state_n = NORMALIZE;
      NORMALIZE: begin
        state_n  = DONE;
        load_res = 1'b1;
        if ($signed(e_n) >= 10'sd255) begin
          res_n = {sign, 8'hFF, 23'd0};
          flg_n = 5'b00010;
        end else if ($signed(e_n) <= 10'sd0) begin
          res_n = {sign, 31'd0};
          flg_n = 5'b00001;
        end else begin
          res_n = {sign, e_n[7:0], (q[24] ? q[23:1] : q[22:0])};
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_r           <= 32'd0;
      b_r           <= 32'd0;
      rem           <= 26'd0;
      q             <= 25'd0;
      cnt           <= 5'd0;
      quotient_o    <= 32'd0;
      nan_o         <= 1'b0;
      infinite_o    <= 1'b0;
      div_by_zero_o <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_i) begin
        a_r <= a_i;
        b_r <= b_i;
      end
      if (state == UNPACK) begin
        rem <= {2'b00, 1'b1, a_r[22:0]};
        q   <= 25'd0;
        cnt <= 5'd0;
      end
      if (state == DIVIDE) begin
        if (rem >= d_ext) begin
          q   <= {q[23:0], 1'b1};
          rem <= {rem_sub[24:0], 1'b0};
        end else begin
          q   <= {q[23:0], 1'b0};
          rem <= {rem[24:0], 1'b0};
        end
        cnt <= cnt + 5'd1;
      end
      if (load_res) begin
        quotient_o <= res_n;
        {nan_o, infinite_o, div_by_zero_o, overflow_o, underflow_o} <= flg_n;
      end
    end
  end

endmodule

// File: tb/tb_ieee754_divider.sv
// tb/tb_ieee754_divider.sv - scoreboard bench for ieee754_divider.
// Edge counts include the edge that samples start_i as edge 1.
module tb_ieee754_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        busy_o, done_o, nan_o, infinite_o, div_by_zero_o, overflow_o, underflow_o;
  logic [31:0] quotient_o;

  ieee754_divider dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o),
    .nan_o(nan_o), .infinite_o(infinite_o), .div_by_zero_o(div_by_zero_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [4:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  wire [4:0] flags = {nan_o, infinite_o, div_by_zero_o, overflow_o, underflow_o};

  function automatic exp_t mk(input logic [31:0] q, input logic [4:0] f, input int lat);
    exp_t r;
    r.q = q; r.f = f; r.lat = lat;
    return r;
  endfunction

  // Reference for finite normal operands whose quotient stays in range
  function automatic exp_t model_normal(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [63:0] num, den, qq;
    int e;
    num = {40'd0, 1'b1, a[22:0]} << 24;
    den = {40'd0, 1'b1, b[22:0]};
    qq  = num / den;
    e   = int'(a[30:23]) - int'(b[30:23]) + (qq[24] ? 127 : 126);
    r.q = {a[31] ^ b[31], 8'(e), (qq[24] ? qq[23:1] : qq[22:0])};
    r.f = 5'd0;
    r.lat = 28;
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit hold);
    int guard;
    guard = 0;
    while (busy_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    sb.push_back(e);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(input int from, output int edges, output bit busy_ok);
    edges = from;
    busy_ok = 1'b1;
    while (!done_o && edges < 64) begin
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({busy_o, done_o, quotient_o, flags} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b done=%b q=%h flags=%b, want all zero", busy_o, done_o, quotient_o, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal;
    logic [31:0] ta [3] = '{32'h40C00000, 32'h3F800000, 32'hBF800000};
    logic [31:0] tb [3] = '{32'h40000000, 32'h40400000, 32'h40400000};
    logic [31:0] tq [3] = '{32'h40400000, 32'h3EAAAAAA, 32'hBEAAAAAA};
    logic [31:0] a, b;
    exp_t e, got;
    int edges;
    bit busy_ok;
    for (int i = 0; i < 9; i++) begin
      if (i < 3) begin
        a = ta[i]; b = tb[i]; e = mk(tq[i], 5'd0, 28);
      end else begin
        a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        e = model_normal(a, b);
      end
      drive(a, b, e, 1'b0);
      wait_done(1, edges, busy_ok);
      got = sb.pop_front();
      vectors++;
      if (edges !== got.lat || !busy_ok) begin
        miscompares++;
        $display("FAIL normal_latency %h/%h: got %0d edges busy_ok=%b, want %0d edges busy_ok=1", a, b, edges, busy_ok, got.lat);
      end
      vectors++;
      if (quotient_o !== got.q || flags !== got.f) begin
        miscompares++;
        $display("FAIL normal %h/%h: got q=%h flags=%b, want q=%h flags=%b", a, b, quotient_o, flags, got.q, got.f);
      end
    end
  endtask

  task automatic test_special;
    logic [31:0] ta [8] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                            32'h3F800000, 32'h7FC00001, 32'hFF800000, 32'h00400000};
    logic [31:0] tb [8] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000,
                            32'h7F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] tq [8] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                            32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h00000000};
    logic [4:0]  tf [8] = '{5'b01100, 5'b01100, 5'b10000, 5'b10000,
                            5'b00000, 5'b10000, 5'b01000, 5'b00000};
    exp_t got;
    int edges;
    bit busy_ok;
    for (int i = 0; i < 8; i++) begin
      drive(ta[i], tb[i], mk(tq[i], tf[i], 2), 1'b0);
      wait_done(1, edges, busy_ok);
      got = sb.pop_front();
      vectors++;
      if (edges !== got.lat) begin
        miscompares++;
        $display("FAIL special_latency %h/%h: got %0d edges, want %0d", ta[i], tb[i], edges, got.lat);
      end
      vectors++;
      if (quotient_o !== got.q || flags !== got.f) begin
        miscompares++;
        $display("FAIL special %h/%h: got q=%h flags=%b, want q=%h flags=%b", ta[i], tb[i], quotient_o, flags, got.q, got.f);
      end
    end
  endtask

  task automatic test_limits;
    logic [31:0] ta [3] = '{32'h7F000000, 32'h00800000, 32'h00800000};
    logic [31:0] tb [3] = '{32'h3E800000, 32'h40000000, 32'h3F800000};
    logic [31:0] tq [3] = '{32'h7F800000, 32'h00000000, 32'h00800000};
    logic [4:0]  tf [3] = '{5'b00010, 5'b00001, 5'b00000};
    exp_t got;
    int edges;
    bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      drive(ta[i], tb[i], mk(tq[i], tf[i], 28), 1'b0);
      wait_done(1, edges, busy_ok);
      got = sb.pop_front();
      vectors++;
      if (edges !== got.lat) begin
        miscompares++;
        $display("FAIL limit_latency %h/%h: got %0d edges, want %0d", ta[i], tb[i], edges, got.lat);
      end
      vectors++;
      if (quotient_o !== got.q || flags !== got.f) begin
        miscompares++;
        $display("FAIL limit %h/%h: got q=%h flags=%b, want q=%h flags=%b", ta[i], tb[i], quotient_o, flags, got.q, got.f);
      end
    end
  endtask

  task automatic test_handshake;
    exp_t got;
    int edges, extra;
    bit busy_ok;
    drive(32'h40C00000, 32'h40000000, mk(32'h40400000, 5'd0, 28), 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      start_i = ~start_i;
      a_i = $urandom;
      b_i = $urandom;
    end
    start_i = 1'b0;
    wait_done(13, edges, busy_ok);
    got = sb.pop_front();
    vectors++;
    if (edges !== got.lat || quotient_o !== got.q || flags !== got.f) begin
      miscompares++;
      $display("FAIL handshake: got %0d edges q=%h flags=%b, want %0d edges q=%h flags=%b", edges, quotient_o, flags, got.lat, got.q, got.f);
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done_o) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL handshake_extra_done: got %0d extra done pulses, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    exp_t got;
    int edges;
    bit busy_ok;
    drive(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 5'd0, 28), 1'b0);
    wait_done(1, edges, busy_ok);
    got = sb.pop_front();
    vectors++;
    if (edges !== got.lat || quotient_o !== got.q || flags !== got.f) begin
      miscompares++;
      $display("FAIL b2b_first: got %0d edges q=%h, want %0d edges q=%h", edges, quotient_o, got.lat, got.q);
    end
    sb.push_back(mk(32'h40400000, 5'd0, 28));
    a_i = 32'h40C00000;
    b_i = 32'h40000000;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b, want busy=0 done=0", busy_o, done_o);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy_o);
    end
    wait_done(1, edges, busy_ok);
    got = sb.pop_front();
    vectors++;
    if (edges !== got.lat || quotient_o !== got.q || flags !== got.f) begin
      miscompares++;
      $display("FAIL b2b_second: got %0d edges q=%h flags=%b, want %0d edges q=%h flags=%b", edges, quotient_o, flags, got.lat, got.q, got.f);
    end
  endtask

  task automatic test_reset_mid;
    exp_t got;
    int edges, extra;
    bit busy_ok;
    drive(32'h40C00000, 32'h40000000, mk(32'h40400000, 5'd0, 28), 1'b0);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = sb.pop_front();
    vectors++;
    if ({busy_o, done_o, quotient_o, flags} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h flags=%b, want all zero", busy_o, done_o, quotient_o, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_spurious: got %0d active cycles after release, want 0", extra);
    end
    drive(32'h40C00000, 32'h40000000, mk(32'h40400000, 5'd0, 28), 1'b0);
    wait_done(1, edges, busy_ok);
    got = sb.pop_front();
    vectors++;
    if (edges !== got.lat || quotient_o !== got.q || flags !== got.f) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got %0d edges q=%h flags=%b, want %0d edges q=%h flags=%b", edges, quotient_o, flags, got.lat, got.q, got.f);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_limits();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
